muldiv_sched: RTL and testbench
===============================

Name: muldiv_sched

Overview:
- Sequencer and owner of the HI/LO registers for the CPU's multiply/divide path.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage.
- For signed ops, converts operands to magnitudes and drives the shared unsigned multiplier and divider units. Waits for their done, applies sign fix-up, writes HI/LO.
- Stalls the pipeline via busy while an operation is in flight.

Parameters:
- WAIT_MAX, 64: maximum cycles spent in a WAIT state before abort.
- CNT_W, 7: width of the wait counter; must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- op_valid  input  1  request strobe from execute stage.
- op_code  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
- rs_val  input  32  rs operand (multiplicand/dividend/MTxx source).
- rt_val  input  32  rt operand (multiplier/divisor).
- busy  output  1  pipeline stall, high while state != IDLE.
- hi  output  32  HI register.
- lo  output  32  LO register.
- timeout_err  output  1  one-cycle pulse on watchdog abort.
- mu_ena  output  1  multiplier enable, level.
- mu_a  output  32  multiplier operand a (registered magnitude).
- mu_b  output  32  multiplier operand b (registered magnitude).
- mu_z  input  64  multiplier product.
- mu_done  input  1  product valid.
- du_ena  output  1  divider enable, level.
- du_dividend  output  32  registered magnitude.
- du_divisor  output  32  registered magnitude.
- du_q  input  32  quotient.
- du_r  input  32  remainder.
- du_done  input  1  quotient/remainder valid.

Behaviour:
- Reset (async):
  - State is IDLE.
  - hi, lo, mu_a, mu_b, du_dividend, du_divisor and the counter are all 0.
  - mu_ena, du_ena, timeout_err and busy are 0.
- States: IDLE, MUL_WAIT, DIV_WAIT, FIXUP.
- busy is decoded from state only (no combinational path from op_valid).
- Acceptance: only when op_valid=1 in IDLE. op_valid while busy is ignored; the stalled stage holds the request.
- Reserved op_code: accepted as a no-op, state stays IDLE.
- MTHI/MTLO: hi (or lo) <= rs_val at the accepting edge; state stays IDLE. Visible the next cycle; no busy.
- MULT/MULTU accept:
  - Latch neg_lo = rs[31]^rt[31] for MULT, 0 for MULTU.
  - mu_a/mu_b <= magnitude(rs)/magnitude(rt) for MULT, raw values for MULTU.
  - mu_ena <= 1; state -> MUL_WAIT.
- DIV/DIVU accept, rt_val != 0:
  - Latch quotient sign rs[31]^rt[31] and remainder sign rs[31]; both 0 for DIVU.
  - Load magnitudes; du_ena <= 1; state -> DIV_WAIT.
- DIV/DIVU accept, rt_val == 0: no unit issued; hi/lo unchanged; state stays IDLE.
- Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- MUL_WAIT/DIV_WAIT:
  - Counter increments each cycle; enable held high.
  - On done: capture the result into an internal 64-bit register, drop the enable, go to FIXUP.
  - If counter reaches WAIT_MAX without done: drop the enable, pulse timeout_err, go to IDLE, hi/lo unchanged.
- FIXUP:
  - MUL: {hi,lo} <= neg ? two's-complement negation of the 64-bit product : product.
  - DIV: lo <= qneg ? -q : q; hi <= rneg ? -r : r.
  - State -> IDLE.
- 0x80000000 / 0xFFFFFFFF (DIV): lo = 0x80000000 (wraps), hi = 0.
- Latency: accept edge + N cycles of unit wait (done sampled) + 1 FIXUP edge. hi/lo are valid the cycle busy falls.
- Reset mid-operation: immediate abort to the reset values above; any pending result is discarded.

Optional Feature:
- Macro: MULDIV_DIVZERO_FLAG_EN.
- With macro defined:
  - Extra output div_zero_err (1 bit), reset 0.
  - Pulses high for one cycle after an accepted DIV/DIVU with rt_val == 0.
  - hi/lo unchanged.
- Without macro: port absent; divide-by-zero is a silent one-cycle no-op.

Test Plan:
- MTHI then MTLO back-to-back, rs_val 0x12345678 / 0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0; busy never asserted.
- MULT rs=0xFFFFFFFE (-2), rt=3; unit model returns mu_z=6 after 5 cycles -> mu_a=2, mu_b=3; hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high exactly 6 cycles.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> operands passed raw; {hi,lo}=0xFFFFFFFE_00000001 from model product.
- DIV rs=0xFFFFFFF9 (-7), rt=2; model q=3, r=1 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Repeat with rt=0 -> hi/lo unchanged; div_zero_err pulses when the macro is defined.
- Model never asserts mu_done, WAIT_MAX=64 -> timeout_err pulses once 64 cycles after the accept edge; mu_ena low; hi/lo unchanged; a new op_valid is accepted the next cycle.
- Assert reset during DIV_WAIT -> busy, du_ena, hi, lo go to 0 without a clock edge; a later du_done is ignored.

Source files
------------

// File: rtl/muldiv_sched_if.sv
// Bundle of execute-stage request/result signals and the multiplier/divider unit
// handshake for muldiv_sched. The div_zero_err pulse exists only when
// MULDIV_DIVZERO_FLAG_EN is defined.
interface muldiv_sched_if;
  // Execute-stage side
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        timeout_err;
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic        div_zero_err;
`endif
  // Shared unsigned multiplier
  logic        mu_ena;
  logic [31:0] mu_a;
  logic [31:0] mu_b;
  logic [63:0] mu_z;
  logic        mu_done;
  // Shared unsigned divider
  logic        du_ena;
  logic [31:0] du_dividend;
  logic [31:0] du_divisor;
  logic [31:0] du_q;
  logic [31:0] du_r;
  logic        du_done;

  // Sequencer side
  modport slave (
    input  op_valid, op_code, rs_val, rt_val,
    output busy, hi, lo, timeout_err,
`ifdef MULDIV_DIVZERO_FLAG_EN
    output div_zero_err,
`endif
    output mu_ena, mu_a, mu_b,
    input  mu_z, mu_done,
    output du_ena, du_dividend, du_divisor,
    input  du_q, du_r, du_done
  );

  // Execute stage plus arithmetic units
  modport master (
    output op_valid, op_code, rs_val, rt_val,
    input  busy, hi, lo, timeout_err,
`ifdef MULDIV_DIVZERO_FLAG_EN
    input  div_zero_err,
`endif
    input  mu_ena, mu_a, mu_b,
    output mu_z, mu_done,
    input  du_ena, du_dividend, du_divisor,
    output du_q, du_r, du_done
  );
endinterface

// File: rtl/muldiv_sched.sv
// Multiply/divide sequencer and HI/LO owner. Signed ops are reduced to magnitudes
// for the shared unsigned multiplier/divider, and the sign is restored in FIXUP.
// A watchdog aborts a unit wait after WAIT_MAX cycles.
// Optional: define MULDIV_DIVZERO_FLAG_EN to get a div_zero_err pulse on DIV/DIVU
// with a zero divisor.
module muldiv_sched #(
  parameter int unsigned WAIT_MAX = 64,
  parameter int unsigned CNT_W    = 7   // 2**CNT_W must exceed WAIT_MAX
) (
  input  logic            clk,
  input  logic            reset,
  muldiv_sched_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StMulWait, StDivWait, StFixup} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        mu_a_q, mu_a_d, mu_b_q, mu_b_d;
  logic [31:0]        dvd_q, dvd_d, dvs_q, dvs_d;
  logic               mu_ena_q, mu_ena_d, du_ena_q, du_ena_d;
  logic [63:0]        res_q, res_d, res_neg;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;  // product sign (MUL) or quotient sign (DIV)
  logic               neg_hi_q, neg_hi_d;  // remainder sign (DIV only)
  logic               timeout_q, timeout_d;
  logic               is_signed, sign_x;
  logic [31:0]        q_neg, r_neg;
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic               dz_q, dz_d;
`endif

  // 0x80000000 maps to itself and is then treated as unsigned.
  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // State and datapath registers; reset discards any in-flight result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mu_a_q    <= '0;
      mu_b_q    <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      mu_ena_q  <= 1'b0;
      du_ena_q  <= 1'b0;
      res_q     <= '0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      timeout_q <= 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mu_a_q    <= mu_a_d;
      mu_b_q    <= mu_b_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      mu_ena_q  <= mu_ena_d;
      du_ena_q  <= du_ena_d;
      res_q     <= res_d;
      is_div_q  <= is_div_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      timeout_q <= timeout_d;
`ifdef MULDIV_DIVZERO_FLAG_EN
      dz_q      <= dz_d;
`endif
    end
  end

  // Next-state: request decode in IDLE, unit wait with watchdog, sign fix-up.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mu_a_d    = mu_a_q;
    mu_b_d    = mu_b_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    mu_ena_d  = mu_ena_q;
    du_ena_d  = du_ena_q;
    res_d     = res_q;
    is_div_d  = is_div_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    timeout_d = 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
    dz_d      = 1'b0;
`endif
    cnt_inc   = cnt_q + CNT_W'(1);
    is_signed = ~bus.op_code[0];
    sign_x    = bus.rs_val[31] ^ bus.rt_val[31];
    res_neg   = ~res_q + 64'd1;
    q_neg     = ~res_q[31:0] + 32'd1;
    r_neg     = ~res_q[63:32] + 32'd1;

    case (state_q)
      StIdle: begin
        if (bus.op_valid) begin
          case (bus.op_code)
            3'b000, 3'b001: begin
              neg_lo_d = is_signed & sign_x;
              neg_hi_d = 1'b0;
              mu_a_d   = is_signed ? mag(bus.rs_val) : bus.rs_val;
              mu_b_d   = is_signed ? mag(bus.rt_val) : bus.rt_val;
              mu_ena_d = 1'b1;
              is_div_d = 1'b0;
              cnt_d    = '0;
              state_d  = StMulWait;
            end
            3'b010, 3'b011: begin
              if (bus.rt_val != 32'd0) begin
                neg_lo_d = is_signed & sign_x;
                neg_hi_d = is_signed & bus.rs_val[31];
                dvd_d    = is_signed ? mag(bus.rs_val) : bus.rs_val;
                dvs_d    = is_signed ? mag(bus.rt_val) : bus.rt_val;
                du_ena_d = 1'b1;
                is_div_d = 1'b1;
                cnt_d    = '0;
                state_d  = StDivWait;
              end else begin
`ifdef MULDIV_DIVZERO_FLAG_EN
                dz_d = 1'b1;
`endif
              end
            end
            3'b100:  hi_d = bus.rs_val;
            3'b101:  lo_d = bus.rs_val;
            default: ;  // reserved codes are a no-op
          endcase
        end
      end
      StMulWait: begin
        cnt_d = cnt_inc;
        if (bus.mu_done) begin
          res_d    = bus.mu_z;
          mu_ena_d = 1'b0;
          state_d  = StFixup;
        end else if (cnt_inc == CNT_W'(WAIT_MAX)) begin
          mu_ena_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StDivWait: begin
        cnt_d = cnt_inc;
        if (bus.du_done) begin
          res_d    = {bus.du_r, bus.du_q};
          du_ena_d = 1'b0;
          state_d  = StFixup;
        end else if (cnt_inc == CNT_W'(WAIT_MAX)) begin
          du_ena_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StFixup: begin
        if (is_div_q) begin
          lo_d = neg_lo_q ? q_neg : res_q[31:0];
          hi_d = neg_hi_q ? r_neg : res_q[63:32];
        end else begin
          {hi_d, lo_d} = neg_lo_q ? res_neg : res_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.timeout_err = timeout_q;
  assign bus.mu_ena      = mu_ena_q;
  assign bus.mu_a        = mu_a_q;
  assign bus.mu_b        = mu_b_q;
  assign bus.du_ena      = du_ena_q;
  assign bus.du_dividend = dvd_q;
  assign bus.du_divisor  = dvs_q;
`ifdef MULDIV_DIVZERO_FLAG_EN
  assign bus.div_zero_err = dz_q;
`endif

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched with behavioural multiplier/divider models and a
// scoreboard of expected {hi,lo} results.
module tb_muldiv_sched;
  logic clk;
  logic reset;
  muldiv_sched_if bus();

  muldiv_sched #(.WAIT_MAX(64), .CNT_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  // Unit models
  int   mu_lat = 5;
  int   du_lat = 3;
  int   mu_cnt, du_cnt;
  logic mu_hang  = 1'b0;
  logic du_force = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mu_cnt <= 0;
      du_cnt <= 0;
    end else begin
      mu_cnt <= bus.mu_ena ? mu_cnt + 1 : 0;
      du_cnt <= bus.du_ena ? du_cnt + 1 : 0;
    end
  end

  always_comb begin
    bus.mu_done = bus.mu_ena && !mu_hang && (mu_cnt == mu_lat - 1);
    bus.mu_z    = 64'(bus.mu_a) * 64'(bus.mu_b);
    bus.du_done = (bus.du_ena && (du_cnt == du_lat - 1)) || du_force;
    bus.du_q    = '1;
    bus.du_r    = bus.du_dividend;
    if (bus.du_divisor != 32'd0) begin
      bus.du_q = bus.du_dividend / bus.du_divisor;
      bus.du_r = bus.du_dividend % bus.du_divisor;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] code, input logic [31:0] rs, input logic [31:0] rt);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.rs_val   = rs;
    bus.rt_val   = rt;
    step();
    bus.op_valid = 1'b0;
  endtask

  // Counts busy cycles from now until busy falls (bounded).
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      step();
    end
    if (n >= 200) chk("busy_bound", 64'(n), 64'd0);
  endtask

  task automatic check_result(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {bus.hi, bus.lo}, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    logic [31:0] hs, ls;
    bus.op_valid = 1'b0;
    bus.op_code  = 3'd0;
    bus.rs_val   = 32'd0;
    bus.rt_val   = 32'd0;
    reset = 1'b1;
    #12;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rst_ena", {62'd0, bus.mu_ena, bus.du_ena}, 64'd0);
    chk("rst_tmo", 64'(bus.timeout_err), 64'd0);
    chk("rst_ops", {bus.mu_a, bus.du_dividend}, 64'd0);
    reset = 1'b0;
    step();

    // MTHI / MTLO back-to-back, never busy
    issue(3'b100, 32'h12345678, 32'd0);
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    chk("mthi_hi", 64'(bus.hi), 64'h12345678);
    issue(3'b101, 32'h9ABCDEF0, 32'd0);
    chk("mtlo_busy", 64'(bus.busy), 64'd0);
    chk("mt_hilo", {bus.hi, bus.lo}, 64'h12345678_9ABCDEF0);

    // MULT -2 * 3
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFA);
    issue(3'b000, 32'hFFFFFFFE, 32'd3);
    chk("mult_ab", {bus.mu_a, bus.mu_b}, {32'd2, 32'd3});
    chk("mult_ena", 64'(bus.mu_ena), 64'd1);
    wait_idle(n);
    chk("mult_busy_cycles", 64'(n), 64'd6);
    check_result("mult_res");
    chk("mult_ena_off", 64'(bus.mu_ena), 64'd0);

    // MULTU passes operands raw
    exp_q.push_back(64'hFFFFFFFE_00000001);
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_ab", {bus.mu_a, bus.mu_b}, 64'hFFFFFFFF_FFFFFFFF);
    wait_idle(n);
    check_result("multu_res");

    // DIV -7 / 2
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
    issue(3'b010, 32'hFFFFFFF9, 32'd2);
    chk("div_ops", {bus.du_dividend, bus.du_divisor}, {32'd7, 32'd2});
    chk("div_ena", 64'(bus.du_ena), 64'd1);
    wait_idle(n);
    chk("div_busy_cycles", 64'(n), 64'd4);
    check_result("div_res");

    // DIV by zero: no-op
    hs = bus.hi;
    ls = bus.lo;
    issue(3'b010, 32'hFFFFFFF9, 32'd0);
    chk("divz_busy", {62'd0, bus.busy, bus.du_ena}, 64'd0);
`ifdef MULDIV_DIVZERO_FLAG_EN
    chk("divz_flag", 64'(bus.div_zero_err), 64'd1);
`endif
    step();
`ifdef MULDIV_DIVZERO_FLAG_EN
    chk("divz_flag_clr", 64'(bus.div_zero_err), 64'd0);
`endif
    chk("divz_hilo", {bus.hi, bus.lo}, {hs, ls});

    // DIV 0x80000000 / -1 wraps
    exp_q.push_back(64'h00000000_80000000);
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
    chk("divmin_ops", {bus.du_dividend, bus.du_divisor}, 64'h80000000_00000001);
    wait_idle(n);
    check_result("divmin_res");

    // DIVU 100 / 7
    exp_q.push_back({32'd2, 32'd14});
    issue(3'b011, 32'd100, 32'd7);
    wait_idle(n);
    check_result("divu_res");

    // Reserved code is a no-op
    issue(3'b110, 32'h1, 32'h1);
    chk("rsvd_busy", 64'(bus.busy), 64'd0);

    // Watchdog abort on a hung multiplier
    hs = bus.hi;
    ls = bus.lo;
    mu_hang = 1'b1;
    issue(3'b000, 32'd5, 32'd6);
    n = 0;
    while (!bus.timeout_err && n < 100) begin
      step();
      n++;
    end
    chk("tmo_cycles", 64'(n), 64'd64);
    chk("tmo_state", {62'd0, bus.mu_ena, bus.busy}, 64'd0);
    chk("tmo_hilo", {bus.hi, bus.lo}, {hs, ls});
    mu_hang = 1'b0;
    issue(3'b101, 32'hCAFEF00D, 32'd0);
    chk("tmo_next_lo", 64'(bus.lo), {32'd0, 32'hCAFEF00D});
    chk("tmo_pulse_clr", 64'(bus.timeout_err), 64'd0);

    // Asynchronous reset during DIV_WAIT
    issue(3'b011, 32'd50, 32'd5);
    chk("rstmid_busy_pre", 64'(bus.busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid_state", {62'd0, bus.busy, bus.du_ena}, 64'd0);
    chk("rstmid_hilo", {bus.hi, bus.lo}, 64'd0);
    step();
    reset = 1'b0;
    du_force = 1'b1;
    step();
    step();
    du_force = 1'b0;
    chk("late_done_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("late_done_busy", 64'(bus.busy), 64'd0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
